// File: rtl/data_mem_responder.sv
// Data-port memory responder: accepts one load/store at a time, waits a
// fixed number of cycles, commits to a word-organised RAM with byte-lane
// writes, returns a one-cycle response and stalls the pipeline meanwhile.
module data_mem_responder #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [3:0]  i_byteEnable,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_err,
  output logic        o_stall
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned CW      = 4;
  localparam logic [CW-1:0] CNT_LOAD = (WAIT_CYCLES == 0) ? '0 : CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;

  // Captured request (bits [1:0] of the address carry no information)
  logic            r_we;
  logic [31:2]     r_addr;
  logic [31:0]     r_wdata;
  logic [3:0]      r_be;

  logic            r_resp_valid;
  logic [31:0]     r_resp_rdata;
  logic            r_resp_err;

  logic [31:0]     r_mem [DEPTH];

  logic            w_accept;
  logic            w_commit;
  logic            w_we;
  logic [31:2]     w_addr;
  logic [31:0]     w_wdata;
  logic [3:0]      w_be;
  logic [AW-1:0]   w_idx;
  logic            w_oor;
  logic            w_mem_we;
  logic            w_unused_addr_lsbs;

  assign w_unused_addr_lsbs = ^i_req_addr[1:0];

  // Next-state logic; the commit edge is whichever edge enters RESP
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_commit = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_req_valid) begin
          w_accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            w_next   = RESP;
            w_commit = 1'b1;
          end else begin
            w_next   = BUSY;
          end
        end
      end
      BUSY: begin
        if (r_cnt == '0) begin
          w_next   = RESP;
          w_commit = 1'b1;
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Commit uses the live request when accept and commit share an edge
  always_comb begin
    w_we    = r_we;
    w_addr  = r_addr;
    w_wdata = r_wdata;
    w_be    = r_be;
    if (r_state == IDLE) begin
      w_we    = i_req_we;
      w_addr  = i_req_addr[31:2];
      w_wdata = i_req_wdata;
      w_be    = i_byteEnable;
    end
  end

  assign w_idx    = w_addr[AW+1:2];
  assign w_oor    = |w_addr[31:AW+2];
  assign w_mem_we = w_commit & w_we & ~w_oor & ~i_reset;

  // Handshake and stall are combinational and forced low during reset
  assign o_req_ready = ~i_reset & (r_state == IDLE);
  assign o_stall     = ~i_reset & (((r_state == IDLE) & i_req_valid) | (r_state == BUSY));

  assign o_resp_valid = r_resp_valid;
  assign o_resp_rdata = r_resp_rdata;
  assign o_resp_err   = r_resp_err;

  // State, wait counter, captured request and response registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_be         <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_resp_valid <= w_commit;
      if (w_accept) begin
        r_we    <= i_req_we;
        r_addr  <= i_req_addr[31:2];
        r_wdata <= i_req_wdata;
        r_be    <= i_byteEnable;
        r_cnt   <= CNT_LOAD;
      end else if ((r_state == BUSY) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_commit) begin
        if (w_oor) begin
          r_resp_rdata <= '0;
          r_resp_err   <= 1'b1;
        end else if (w_we) begin
          r_resp_rdata <= '0;
          r_resp_err   <= 1'b0;
        end else begin
          r_resp_rdata <= r_mem[w_idx];
          r_resp_err   <= 1'b0;
        end
      end
    end
  end

  // Byte-lane RAM write on the commit edge; contents are never reset
  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: instance 0 uses WAIT_CYCLES=2, instance 1 WAIT_CYCLES=0.
module tb_data_mem_responder;

  localparam int unsigned W0 = 2;
  localparam int unsigned W1 = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v   [2];
  logic        we  [2];
  logic [31:0] addr[2];
  logic [31:0] wd  [2];
  logic [3:0]  be  [2];
  logic        rdy [2];
  logic        rv  [2];
  logic [31:0] rd  [2];
  logic        er  [2];
  logic        st  [2];

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] cyc      = '0;
  int          stall_cnt   [2];
  logic        chk_rdy_next[2];

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 32'd1;

  data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(W0)) dut0 (
    .i_clk(clk), .i_reset(rst), .i_req_valid(v[0]), .o_req_ready(rdy[0]),
    .i_req_we(we[0]), .i_req_addr(addr[0]), .i_req_wdata(wd[0]),
    .i_byteEnable(be[0]), .o_resp_valid(rv[0]), .o_resp_rdata(rd[0]),
    .o_resp_err(er[0]), .o_stall(st[0]));

  data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(W1)) dut1 (
    .i_clk(clk), .i_reset(rst), .i_req_valid(v[1]), .o_req_ready(rdy[1]),
    .i_req_we(we[1]), .i_req_addr(addr[1]), .i_req_wdata(wd[1]),
    .i_byteEnable(be[1]), .o_resp_valid(rv[1]), .o_resp_rdata(rd[1]),
    .o_resp_err(er[1]), .o_stall(st[1]));

  function automatic int unsigned wait_of(int s);
    return (s == 0) ? W0 : W1;
  endfunction

  function automatic int qsize(int s);
    return (s == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t qpop(int s);
    if (s == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  task automatic chk(string nm, int s, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d t=%0t: got 0x%08h expected 0x%08h", nm, s, $time, act, exp);
    end
  endtask

  // Monitor: pops expected response whenever a DUT presents resp_valid
  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      exp_t e;
      if (!rst) begin
        if (st[s]) stall_cnt[s]++;
        if (chk_rdy_next[s]) begin
          chk("ready_after_resp", s, 32'(rdy[s]), 32'd1);
          chk_rdy_next[s] = 1'b0;
        end
        if (rv[s]) begin
          if (qsize(s) == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_resp inst=%0d t=%0t: got resp_valid=1 expected none", s, $time);
          end else begin
            e = qpop(s);
            chk("resp_rdata", s, rd[s], e.rdata);
            chk("resp_err", s, 32'(er[s]), 32'(e.err));
            chk("resp_cycle", s, cyc, e.cyc);
          end
          chk("ready_in_resp", s, 32'(rdy[s]), 32'd0);
          chk("stall_in_resp", s, 32'(st[s]), 32'd0);
          chk_rdy_next[s] = 1'b1;
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accept edge
  task automatic issue(int s, logic w, logic [31:0] a, logic [31:0] d, logic [3:0] b,
                       logic [31:0] exp_rd, logic exp_err, bit push = 1'b1, bit hold = 1'b0);
    int   n;
    exp_t e;
    n = 0;
    v[s] = 1'b1; we[s] = w; addr[s] = a; wd[s] = d; be[s] = b;
    while (!rdy[s] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rdy[s]) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout inst=%0d: got req_ready=0 expected 1 within 50 cycles", s);
      v[s] = 1'b0;
      return;
    end
    if (push) begin
      e.rdata = exp_rd;
      e.err   = exp_err;
      e.cyc   = cyc + 32'd1 + 32'(wait_of(s));
      if (s == 0) q0.push_back(e); else q1.push_back(e);
    end
    @(posedge clk); #1;
    if (!hold) v[s] = 1'b0;
  endtask

  task automatic drain(int s);
    int n;
    n = 0;
    while (qsize(s) != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (qsize(s) != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout inst=%0d: got %0d pending expected 0", s, qsize(s));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    for (int s = 0; s < 2; s++) begin
      v[s] = 1'b0; we[s] = 1'b0; addr[s] = '0; wd[s] = '0; be[s] = '0;
      stall_cnt[s] = 0; chk_rdy_next[s] = 1'b0;
    end

    // Reset state, with a request pending to show stall/ready are gated
    repeat (2) @(posedge clk);
    #1;
    v[0] = 1'b1; v[1] = 1'b1;
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("rst_ready", s, 32'(rdy[s]), 32'd0);
      chk("rst_stall", s, 32'(st[s]), 32'd0);
      chk("rst_resp_valid", s, 32'(rv[s]), 32'd0);
      chk("rst_rdata", s, rd[s], 32'd0);
      chk("rst_err", s, 32'(er[s]), 32'd0);
    end
    v[0] = 1'b0; v[1] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 0, 32'(rdy[0]), 32'd1);
    chk("ready_after_rst", 1, 32'(rdy[1]), 32'd1);
    @(posedge clk); #1;

    // Full-word store then load, with latency and stall length
    issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
    drain(0);
    s0 = stall_cnt[0];
    issue(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
    drain(0);
    chk("stall_cycles", 0, 32'(stall_cnt[0] - s0), 32'd3);

    // Byte-lane merge and empty byte-enable
    issue(0, 1'b1, 32'h14, 32'h11223344, 4'hF, 32'h0, 1'b0);
    issue(0, 1'b1, 32'h14, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0);
    issue(0, 1'b0, 32'h14, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);
    issue(0, 1'b1, 32'h14, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0);
    issue(0, 1'b0, 32'h14, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);
    drain(0);

    // Range boundary and out-of-range accesses
    issue(0, 1'b1, 32'h0, 32'h12345678, 4'hF, 32'h0, 1'b0);
    issue(0, 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
    issue(0, 1'b0, 32'h400, 32'h0, 4'h0, 32'h0, 1'b1);
    issue(0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h12345678, 1'b0);
    issue(0, 1'b1, 32'h3FC, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b0);
    issue(0, 1'b0, 32'h3FF, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b0);
    issue(0, 1'b0, 32'hFFFFFFFC, 32'h0, 4'h0, 32'h0, 1'b1);
    drain(0);

    // Zero wait states: response the cycle after accept
    issue(1, 1'b1, 32'h8, 32'h01020304, 4'hF, 32'h0, 1'b0);
    issue(1, 1'b0, 32'h8, 32'h0, 4'h0, 32'h01020304, 1'b0);
    drain(1);

    // Reset during BUSY of a store drops it
    issue(0, 1'b1, 32'h20, 32'h0, 4'hF, 32'h0, 1'b0);
    issue(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
    drain(0);
    issue(0, 1'b1, 32'h20, 32'hCAFEBABE, 4'hF, 32'h0, 1'b0, 1'b0);
    chk("stall_busy", 0, 32'(st[0]), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_resp_valid", 0, 32'(rv[0]), 32'd0);
    chk("midrst_rdata", 0, rd[0], 32'd0);
    chk("midrst_err", 0, 32'(er[0]), 32'd0);
    chk("midrst_ready", 0, 32'(rdy[0]), 32'd0);
    chk("midrst_stall", 0, 32'(st[0]), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    issue(0, 1'b0, 32'h20, 32'h0, 4'h0, 32'h0, 1'b0);
    drain(0);

    // Back-to-back loads with req_valid held high
    issue(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1);
    issue(0, 1'b0, 32'h14, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, 1'b1, 1'b1);
    issue(0, 1'b0, 32'h0,  32'h0, 4'h0, 32'h12345678, 1'b0, 1'b1, 1'b1);
    issue(0, 1'b0, 32'h3FC, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b0, 1'b1, 1'b0);
    drain(0);
    drain(1);
    repeat (3) @(posedge clk);
    #1;
    chk("queues_empty", 0, 32'(q0.size() + q1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
